// File: rtl/work_serial_transmit.sv
// UART 8N1 transmitter for one 512-bit mining work unit (midstate then data2, byte 0 first, LSB first).
// Optional trailing XOR checksum byte when WORK_TX_CHECKSUM_EN is defined.
module work_serial_transmit #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned GAP_BITS     = 0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         send,
    input  logic [255:0] midstate,
    input  logic [255:0] data2,
    output logic         TxD,
    output logic         busy,
    output logic         done
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_GAP   = 3'd4
    } state_e;

`ifdef WORK_TX_CHECKSUM_EN
    localparam logic [6:0] LAST_COUNT = 7'd65;
`else
    localparam logic [6:0] LAST_COUNT = 7'd64;
`endif
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [3:0]  GAP_LAST  = 4'(GAP_BITS - 1);

    state_e         state_q;
    logic [511:0]   shreg_q;
    logic [511:0]   shreg_d;
    logic [6:0]     byte_cnt_q;
    logic [6:0]     byte_cnt_d;
    logic [2:0]     bit_cnt_q;
    logic [15:0]    baud_q;
    logic [3:0]     gap_cnt_q;
    logic           tx_q;
    logic           busy_q;
    logic           done_q;
    logic [7:0]     cur_byte_s;
    logic           baud_wrap_s;
    logic           byte_end_s;
    logic           more_bytes_s;
`ifdef WORK_TX_CHECKSUM_EN
    logic [7:0]     csum_q;
    logic [7:0]     csum_d;
`endif

    assign cur_byte_s  = shreg_q[7:0];
    assign baud_wrap_s = (baud_q == BAUD_LAST);

    // The last bit of a byte ends on the stop-bit wrap when there is no gap, else on the final gap bit
    assign byte_end_s = baud_wrap_s &&
                        (((state_q == ST_STOP) && (GAP_BITS == 32'd0)) ||
                         ((state_q == ST_GAP) && (gap_cnt_q == GAP_LAST)));

    // Next-byte values: shift out the finished byte and, with checksum, splice the XOR in as byte 64
    always_comb begin
        shreg_d      = {8'h00, shreg_q[511:8]};
        byte_cnt_d   = byte_cnt_q + 7'd1;
        more_bytes_s = (byte_cnt_d < LAST_COUNT);
`ifdef WORK_TX_CHECKSUM_EN
        csum_d = csum_q ^ cur_byte_s;
        if (byte_cnt_d == 7'd64) begin
            shreg_d[7:0] = csum_d;
        end else begin
            shreg_d[7:0] = shreg_q[15:8];
        end
`endif
    end

    // Frame sequencer: baud timing, bit and byte stepping, registered line outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            shreg_q    <= 512'd0;
            byte_cnt_q <= 7'd0;
            bit_cnt_q  <= 3'd0;
            baud_q     <= 16'd0;
            gap_cnt_q  <= 4'd0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef WORK_TX_CHECKSUM_EN
            csum_q     <= 8'd0;
`endif
        end else begin
            done_q <= 1'b0;
            if (byte_end_s) begin
                // The start bit of the next byte begins on this same edge
                baud_q     <= 16'd0;
                shreg_q    <= shreg_d;
                byte_cnt_q <= byte_cnt_d;
`ifdef WORK_TX_CHECKSUM_EN
                csum_q     <= csum_d;
`endif
                if (more_bytes_s) begin
                    state_q   <= ST_START;
                    bit_cnt_q <= 3'd0;
                    tx_q      <= 1'b0;
                end else begin
                    state_q <= ST_IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        tx_q   <= 1'b1;
                        baud_q <= 16'd0;
                        if (send) begin
                            shreg_q    <= {data2, midstate};
                            busy_q     <= 1'b1;
                            tx_q       <= 1'b0;
                            state_q    <= ST_START;
                            byte_cnt_q <= 7'd0;
                            bit_cnt_q  <= 3'd0;
                            gap_cnt_q  <= 4'd0;
`ifdef WORK_TX_CHECKSUM_EN
                            csum_q     <= 8'd0;
`endif
                        end
                    end
                    ST_START: begin
                        if (baud_wrap_s) begin
                            baud_q    <= 16'd0;
                            state_q   <= ST_DATA;
                            bit_cnt_q <= 3'd0;
                            tx_q      <= cur_byte_s[0];
                        end else begin
                            baud_q <= baud_q + 16'd1;
                        end
                    end
                    ST_DATA: begin
                        if (baud_wrap_s) begin
                            baud_q <= 16'd0;
                            if (bit_cnt_q == 3'd7) begin
                                state_q <= ST_STOP;
                                tx_q    <= 1'b1;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 3'd1;
                                tx_q      <= cur_byte_s[bit_cnt_q + 3'd1];
                            end
                        end else begin
                            baud_q <= baud_q + 16'd1;
                        end
                    end
                    ST_STOP: begin
                        if (baud_wrap_s) begin
                            baud_q    <= 16'd0;
                            state_q   <= ST_GAP;
                            gap_cnt_q <= 4'd0;
                        end else begin
                            baud_q <= baud_q + 16'd1;
                        end
                    end
                    ST_GAP: begin
                        if (baud_wrap_s) begin
                            baud_q    <= 16'd0;
                            gap_cnt_q <= gap_cnt_q + 4'd1;
                        end else begin
                            baud_q <= baud_q + 16'd1;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        tx_q    <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign TxD  = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: doc/work_serial_transmit.md
# work_serial_transmit

UART transmitter for one mining work unit: 256-bit midstate plus 256-bit data2, sent as 64 bytes in 8N1 framing. It is the sending end of the link that `serial_receive` decodes inside the miner. It serves as the work source on a master board that feeds slave miners, and as the stimulus driver in loopback benches. Work is latched on a send/busy handshake, and a one-cycle `done` pulse marks the end of the frame.

## Interface
- `CLKS_PER_BIT`, 434: clock cycles per UART bit (50 MHz / 115200). Legal range 2..65535.
- `GAP_BITS`, 0: extra idle-high bit times after each stop bit. Legal range 0..15.
- `clk`  in  1: single clock; all logic is on its rising edge.
- `reset_n`  in  1: synchronous, active-low reset.
- `send`  in  1: request to transmit; accepted only when `busy`=0.
- `midstate`  in  256: first half of the work; sampled on acceptance.
- `data2`  in  256: second half of the work; sampled on acceptance.
- `TxD`  out  1: serial line, registered, idles high.
- `busy`  out  1: high from acceptance until the frame completes.
- `done`  out  1: one-cycle pulse on frame completion.

## Operation
- Reset values: `TxD`=1, `busy`=0, `done`=0, state=IDLE, byte counter=0, bit counter=0, baud counter=0.
- Acceptance: `send`=1 and `busy`=0 at a rising edge. At that edge the block captures {data2, midstate} into a 512-bit shift register, sets `busy`=1, drives `TxD`=0 (start bit) and enters START.
- `send` while `busy`=1 is ignored. There is no queuing, and the shift register is not disturbed.
- Byte order:
  - byte k (0..31) = midstate[8k+7:8k];
  - byte 32+k = data2[8k+7:8k];
  - within each byte, bits are sent LSB first.
- States:
  - IDLE: `TxD`=1; wait for acceptance.
  - START: `TxD`=0 for one bit time, then go to DATA.
  - DATA: 8 bit times, LSB first, using a 3-bit bit counter; then go to STOP.
  - STOP: `TxD`=1 for one bit time. Next state is GAP if `GAP_BITS`>0, otherwise NEXT.
  - GAP: `TxD`=1 for `GAP_BITS` bit times.
  - NEXT: shift the register right by 8 and increment the 7-bit byte counter. If the count is below 64, go to START with zero extra cycles: the start bit begins on the same edge as the NEXT decision. Otherwise go to IDLE and end the frame.
- Baud counter: 16-bit, counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary. The bit advance happens on the wrap.
- Frame end: at the edge that completes the final stop/gap bit, the block sets `busy`=0 and `done`=1. `done` clears on the next edge.
- Back-to-back frames: `send` held high is accepted on the edge after `busy` falls. This is the cycle in which `done`=1, so the line is high for exactly one clock between frames.
- Reset mid-frame: on the next edge all outputs return to reset values and the partial frame is discarded. `done` is not pulsed.
- The register holding `midstate` and `data2` is not updated during a frame; the inputs may change freely while `busy`=1.

## Timing
- Latency from acceptance edge to start bit visible on `TxD`: 0 cycles after the edge, since `TxD` is registered at the acceptance edge.
- Byte time = (10+GAP_BITS)*CLKS_PER_BIT cycles.
- Frame time (acceptance edge to `done` edge) = 64*(10+GAP_BITS)*CLKS_PER_BIT cycles, or 65*(...) with the checksum option.
- Every bit is exactly CLKS_PER_BIT cycles long, with no jitter.
- Minimum send-to-send period = frame time + 1 cycle.

## Configuration
- `WORK_TX_CHECKSUM_EN` defined:
  - after byte 63, one extra byte is sent: the XOR of all 64 payload bytes, accumulated as the bytes are shifted out;
  - byte counter terminal count is 65;
  - `done` follows the checksum byte's stop/gap bits.
- `WORK_TX_CHECKSUM_EN` undefined: the frame is exactly 64 bytes and no accumulator logic is synthesized.

## Test plan
- Single frame, CLKS_PER_BIT=4, GAP_BITS=0, midstate=256'h...0201A5 (byte0=A5, byte1=01, byte2=02), data2=0 -> required response:
  - TxD low for 4 cycles starting at the acceptance edge;
  - first data bits 1,0,1,0,0,1,0,1;
  - 64 decoded bytes match;
  - `done` pulses exactly 2560 cycles after acceptance.
- `send` pulsed at byte 10 of an active frame with different data -> frame continues unchanged; `busy` stays high; no second frame starts.
- `send` held high continuously -> two frames separated by exactly one idle-high clock; `done` pulses twice, 2561 cycles apart.
- `reset_n`=0 for one cycle mid-byte 20 -> next edge TxD=1, busy=0, done never pulses; a subsequent `send` produces a complete correct frame.
- GAP_BITS=2, CLKS_PER_BIT=4 -> each byte occupies 48 cycles with 12 idle-high cycles after the data bits; frame time is 3072 cycles.
- `WORK_TX_CHECKSUM_EN` defined, midstate=all 8'h11, data2=0 -> a 65th byte 8'h00 is sent and `done` arrives at 2600 cycles. Repeat with byte0 changed to 8'h10 -> checksum 8'h01.
